// File: rtl/serv_imm_seq_pkg.sv
// Shared types and constants for the immediate-decoder sequencer.
// Optional capture path: SERV_IMM_SEQ_CAPTURE_EN.
package serv_imm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RUN,
    DONE
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  // {ctrl[3:0], en[3:0], csr}
  typedef struct packed {
    logic [3:0] ctrl;
    logic [3:0] en;
    logic       csr;
  } imm_cfg_t;

  localparam logic [8:0] IMM_CFG_I    = 9'b0010_1100_0;
  localparam logic [8:0] IMM_CFG_S    = 9'b0011_1001_0;
  localparam logic [8:0] IMM_CFG_B    = 9'b0101_1001_0;
  localparam logic [8:0] IMM_CFG_U    = 9'b1010_1110_0;
  localparam logic [8:0] IMM_CFG_J    = 9'b1000_1110_0;
  localparam logic [8:0] IMM_CFG_Z    = 9'b1000_0010_1;
  localparam logic [8:0] IMM_CFG_NONE = 9'b0000_0000_0;

endpackage

// File: rtl/serv_imm_seq_dec.sv
// Opcode/funct3 to immediate-decoder configuration lookup.
// Purely combinational; shared with the decoder bench.
module serv_imm_seq_dec
  import serv_imm_seq_pkg::*;
(
  input  logic [4:0] op,
  input  logic [2:0] f3,
  output logic [8:0] cfg
);

  logic unused_f3;
  assign unused_f3 = ^f3[1:0];

  always_comb begin
    cfg = IMM_CFG_NONE;
    unique case (1'b1)
      (op == OP_LOAD) || (op == OP_OPIMM) || (op == OP_JALR):
        cfg = IMM_CFG_I;
      (op == OP_STORE):
        cfg = IMM_CFG_S;
      (op == OP_BRANCH):
        cfg = IMM_CFG_B;
      (op == OP_LUI) || (op == OP_AUIPC):
        cfg = IMM_CFG_U;
      (op == OP_JAL):
        cfg = IMM_CFG_J;
      (op == OP_SYSTEM) && f3[2]:
        cfg = IMM_CFG_Z;
      default:
        cfg = IMM_CFG_NONE;
    endcase
  end

endmodule

// File: rtl/serv_imm_seq.sv
// Fetch-to-decode sequencer driving the bit-serial immediate decoder.
// Define SERV_IMM_SEQ_CAPTURE_EN to add the o_imm_word capture port.
module serv_imm_seq
  import serv_imm_seq_pkg::*;
#(
  parameter int TIMEOUT      = 16,
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_halt,
  output logic        o_ibus_cyc,
  input  logic        i_ibus_ack,
  input  logic [31:0] i_ibus_rdt,
  output logic        o_wb_en,
  output logic        o_cnt_en,
  output logic        o_cnt_done,
  output logic [4:0]  o_cnt,
  output logic [3:0]  o_immdec_en,
  output logic [3:0]  o_ctrl,
  output logic        o_csr_imm_en,
  input  logic        i_imm,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault
`ifdef SERV_IMM_SEQ_CAPTURE_EN
  ,
  output logic [31:0] o_imm_word
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t   state;
  state_t   state_nxt;
  imm_cfg_t cfg;
  imm_cfg_t dec_cfg;
  logic [4:0] cnt;
  logic [7:0] wait_cnt;
  logic       fault;
  logic       booted;
  logic       run;
  logic       hold;
  logic       timeout;
  logic [8:0] dec_out;

  serv_imm_seq_dec u_dec (
    .op  (i_ibus_rdt[6:2]),
    .f3  (i_ibus_rdt[14:12]),
    .cfg (dec_out)
  );

  assign dec_cfg = dec_out;

  assign run          = (state == RUN);
  assign hold         = run || (state == DONE);
  assign o_ibus_cyc   = (state == FETCH);
  assign o_wb_en      = o_ibus_cyc & i_ibus_ack;
  assign o_cnt_en     = run & ~i_halt;
  assign o_cnt_done   = o_cnt_en & (cnt == 5'd31);
  assign o_cnt        = run ? cnt : 5'd0;
  assign o_immdec_en  = cfg.en & {4{o_cnt_en}};
  assign o_ctrl       = hold ? cfg.ctrl : 4'd0;
  assign o_csr_imm_en = hold & cfg.csr;
  assign o_busy       = (state != IDLE);
  assign o_done       = (state == DONE);
  assign o_fault      = fault;
  assign timeout      = ~i_ibus_ack & (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (i_start || (RUN_ON_RESET && !booted))
          state_nxt = FETCH;
      FETCH:
        if (i_ibus_ack)
          state_nxt = RUN;
        else if (timeout)
          state_nxt = IDLE;
      RUN:
        if (o_cnt_done)
          state_nxt = DONE;
      DONE:
        state_nxt = i_start ? FETCH : IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cfg      <= '0;
      cnt      <= '0;
      wait_cnt <= '0;
      fault    <= 1'b0;
      booted   <= 1'b0;
    end else begin
      state  <= state_nxt;
      booted <= 1'b1;
      if (state == FETCH) begin
        if (i_ibus_ack) begin
          cfg <= dec_cfg;
          cnt <= '0;
        end
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (o_cnt_en)
        cnt <= cnt + 5'd1;
      if ((state == IDLE) && i_start)
        fault <= 1'b0;
      else if ((state == FETCH) && timeout)
        fault <= 1'b1;
    end
  end

`ifdef SERV_IMM_SEQ_CAPTURE_EN
  logic [31:0] sr;

  // First serial bit ends up in bit 0 after 32 shifts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sr         <= '0;
      o_imm_word <= '0;
    end else begin
      if (o_cnt_en)
        sr <= {i_imm, sr[31:1]};
      if (o_cnt_done)
        o_imm_word <= {i_imm, sr[31:1]};
    end
  end

  logic unused_rdt;
  assign unused_rdt = ^{i_ibus_rdt[31:15], i_ibus_rdt[11:7],
                        i_ibus_rdt[1:0]};
`else
  logic unused_rdt;
  assign unused_rdt = ^{i_ibus_rdt[31:15], i_ibus_rdt[11:7],
                        i_ibus_rdt[1:0], i_imm};
`endif

endmodule
